decode_ctrl_queue: RTL
======================

// Module: decode_ctrl_queue
// PURPOSE
//  Registered successor to the combinational main decoder: decodes opcode/funct3 into a widened
//  control word, flags illegal encodings, and buffers word+payload in a DEPTH-entry FIFO between
//  fetch and ID/EX with valid/ready on both sides. Decouples decode from EX back-pressure and
//  gives flush/bubble semantics for branch redirect.
// PARAMETERS
//  PAYLOAD_W  64  opaque sideband carried with each entry (e.g. {pc, instr}); not interpreted
//  DEPTH      2   FIFO entries; power of two, >=2
// PORTS
//  clk         in   1          single clock; all state updates on rising edge
//  reset       in   1          synchronous, active-high
//  flush       in   1          sync discard of all entries and the same-cycle push
//  in_valid    in   1          op/funct3/payload valid
//  in_ready    out  1          queue can accept this cycle
//  op          in   7          instr[6:0]
//  funct3      in   3          instr[14:12]
//  payload_in  in   PAYLOAD_W  sideband
//  out_valid   out  1          head entry valid
//  out_ready   in   1          consumer takes head this cycle
//  payload_out out  PAYLOAD_W  head sideband
//  RegWrite, ALUSrc, MemWrite, Branch, Jump, Jalr, Auipc, Sys, Illegal  out 1 each
//  ImmSrc      out  3          000 I, 001 S, 010 B, 011 J, 100 U
//  ResultSrc   out  2          00 ALU, 01 mem, 10 PC+4, 11 imm/upper
//  ALUOp       out  2          00 add, 01 branch-cmp, 10 funct-decoded
// BEHAVIOUR
//  Decode table (RegWrite ImmSrc ALUSrc MemWrite ResultSrc ALUOp Jump Jalr Branch Auipc):
//   0000011 load 1 000 1 0 01 00 0 0 0 0 | 0100011 store 0 001 1 1 00 00 0 0 0 0
//   0110011 R    1 000 0 0 00 10 0 0 0 0 | 0010011 I-ALU 1 000 1 0 00 10 0 0 0 0
//   1100011 br   0 010 0 0 00 01 0 0 1 0 | 0110111 lui   1 100 1 0 11 00 0 0 0 0
//   0010111 auipc 1 100 1 0 11 00 0 0 0 1 | 1100111 jalr  1 000 1 0 10 00 0 1 0 0
//   1101111 jal  1 011 0 0 10 00 1 0 0 0
//  No X outputs. Unlisted opcode -> all fields 0, Illegal=1.
//  funct3 legality: load {000,001,010,100,101}; store {000,001,010}; branch not {010,011};
//   jalr 000. Illegal funct3 -> Illegal=1; RegWrite/MemWrite/Branch/Jump/Jalr forced 0.
//  Decode is combinational on the input side; decoded word is stored, never re-decoded.
//  Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
//  in_ready = (count != DEPTH); registered-state only, no combinational path from out_ready.
//  Latency: entry pushed at edge N appears at out_valid at N+1 (empty queue).
//  Push+pop same cycle: count unchanged, both pointers advance; legal at any count < DEPTH.
//  Full: in_ready=0; in_valid ignored. Empty: out_valid=0, all control outputs and payload_out 0.
//  Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  out_* held stable while out_valid & ~out_ready.
//  flush: at next edge count=0, pointers=0, out_valid=0; beats pushed or popped in the
//   flush cycle are discarded (pop side effects are the consumer's concern).
//  reset: same as flush; all outputs 0, in_ready=1 after the edge. reset beats flush.
// CONFIGURATION
//  DECODE_SYSTEM_EN defined: op 1110011 -> Sys=1, RegWrite=(funct3!=000), ImmSrc 000,
//   ResultSrc 00, others 0; funct3 100 -> Illegal=1.
//  Not defined: 1110011 -> Illegal=1, Sys tied 0.
// TESTING
//  1 reset 2 cycles -> out_valid=0, in_ready=1, all controls 0.
//  2 push op=0000011 f3=010 payload=0xA -> next cycle out_valid=1, RegWrite=1, ResultSrc=01,
//    ALUSrc=1, payload_out=0xA; pop -> out_valid=0.
//  3 out_ready=0, push 3 beats (DEPTH=2) -> 3rd refused (in_ready=0); release -> beats 1,2 in order.
//  4 push+pop every cycle, 8 beats (jal, lui, auipc, br f3=000...) -> order kept, count 1,
//    jal: Jump=1 ImmSrc=011 ResultSrc=10; auipc: Auipc=1 ResultSrc=11.
//  5 op=1100011 f3=010 and op=0000000 -> Illegal=1, Branch=0, RegWrite=0.
//  6 queue full, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed beat lost;
//    repeat 1110011 f3=001 both macro settings -> Sys=1 RegWrite=1 vs Illegal=1.

Source files
------------

// File: rtl/decode_ctrl_queue.sv
// decode_ctrl_queue: decodes opcode/funct3 into a control word and queues it with its payload.
// Build option: define DECODE_SYSTEM_EN to decode SYSTEM (1110011); otherwise it is flagged illegal.
module decode_ctrl_queue #(
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic                 RegWrite,
    output logic                 ALUSrc,
    output logic                 MemWrite,
    output logic                 Branch,
    output logic                 Jump,
    output logic                 Jalr,
    output logic                 Auipc,
    output logic                 Sys,
    output logic                 Illegal,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUOp
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       auipc;
        logic       sys;
        logic       illegal;
    } ctrl_t;

    // Table row layout: RegWrite ImmSrc ALUSrc MemWrite ResultSrc ALUOp Jump Jalr Branch Auipc
    logic [13:0] row;
    logic        known;
    logic        f3_ok;
    logic        sys_op;
    ctrl_t       dec;

    ctrl_t                ctrl_mem_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_mem_q  [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop;
    ctrl_t                head;

    // Input-side decode; illegal funct3 suppresses every architectural side effect
    always_comb begin
        row    = '0;
        known  = 1'b1;
        f3_ok  = 1'b1;
        sys_op = 1'b0;
        case (op)
            7'b0000011: begin
                row   = 14'b1_000_1_0_01_00_0_0_0_0;
                f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            7'b0100011: begin
                row   = 14'b0_001_1_1_00_00_0_0_0_0;
                f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            7'b0110011: row = 14'b1_000_0_0_00_10_0_0_0_0;
            7'b0010011: row = 14'b1_000_1_0_00_10_0_0_0_0;
            7'b1100011: begin
                row   = 14'b0_010_0_0_00_01_0_0_1_0;
                f3_ok = !(funct3 inside {3'b010, 3'b011});
            end
            7'b0110111: row = 14'b1_100_1_0_11_00_0_0_0_0;
            7'b0010111: row = 14'b1_100_1_0_11_00_0_0_0_1;
            7'b1100111: begin
                row   = 14'b1_000_1_0_10_00_0_1_0_0;
                f3_ok = funct3 == 3'b000;
            end
            7'b1101111: row = 14'b1_011_0_0_10_00_1_0_0_0;
`ifdef DECODE_SYSTEM_EN
            7'b1110011: begin
                sys_op = 1'b1;
                row    = {funct3 != 3'b000, 13'b0};
                f3_ok  = funct3 != 3'b100;
            end
`endif
            default: known = 1'b0;
        endcase
        dec.reg_write  = row[13] & f3_ok;
        dec.imm_src    = row[12:10];
        dec.alu_src    = row[9];
        dec.mem_write  = row[8] & f3_ok;
        dec.result_src = row[7:6];
        dec.alu_op     = row[5:4];
        dec.jump       = row[3] & f3_ok;
        dec.jalr       = row[2] & f3_ok;
        dec.branch     = row[1] & f3_ok;
        dec.auipc      = row[0];
        dec.sys        = sys_op;
        dec.illegal    = ~known | ~f3_ok;
    end

    // in_ready depends only on registered count so no path exists from out_ready
    assign in_ready  = count_q != CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Pointer/count next state; flush discards both the stored and the same-cycle beats
    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // Queue bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through out_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            ctrl_mem_q[wr_ptr_q] <= dec;
            pay_mem_q[wr_ptr_q]  <= payload_in;
        end
    end

    // Head is gated to zero when empty so outputs never show stale or undefined data
    assign head        = out_valid ? ctrl_mem_q[rd_ptr_q] : '0;
    assign payload_out = out_valid ? pay_mem_q[rd_ptr_q] : '0;
    assign {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp,
            Jump, Jalr, Branch, Auipc, Sys, Illegal} = head;
endmodule
